i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  Serialises the final mixed stereo samples (al/ar from the audio output stage) into an I2S stream for the HDMI/codec path.
//  Sits directly downstream of the mixer and consumes one L/R pair per sample_ce.
//  Bit clock is generated from clk by a fractional accumulator, so clk need not be a multiple of BCLK.
//  Frame: 64 BCLK slots, 32 per channel; 16-bit MSB-first words, remaining slots zero.
// PARAMETERS
//  CLK_RATE   24576000  clk frequency in Hz; used as the accumulator modulus
//  AUDIO_RATE 48000     base sample rate in Hz
// PORTS
//  clk          in   1   system clock; the only clock
//  reset_n      in   1   asynchronous, active-low reset
//  sample_rate  in   1   0 = 48 kHz, 1 = 96 kHz
//  sample_ce    in   1   one-clk strobe: left/right are valid
//  left         in   16  signed left sample
//  right        in   16  signed right sample
//  i2s_bclk     out  1   bit clock, 64*fs
//  i2s_lrclk    out  1   word select: 0 = left, 1 = right
//  i2s_data     out  1   serial data, changes on BCLK falling edge
//  underrun     out  1   one-clk pulse when a frame starts without a fresh sample
// BEHAVIOUR
//  Reset (async, reset_n=0): every output and register is 0, including the accumulator, slot counter, holding and shift regs.
//  Tick generator:
//   - rate = (128*AUDIO_RATE) << sample_rate, i.e. 6144000 or 12288000.
//   - Each clk: acc += rate; if acc >= CLK_RATE then acc -= CLK_RATE and tick = 1.
//   - Use a 32-bit accumulator.
//  On tick, bclk toggles. When a tick drives bclk 1->0:
//   - slot (6-bit) increments and wraps 63 -> 0.
//   - i2s_lrclk and i2s_data are updated in the same clk, registered.
//  Slot mapping, I2S standard with a 1-BCLK delay:
//   - lrclk = slot[5].
//   - data = word bit (16 - slot[4:0]) for slot[4:0] in 1..16, else 0.
//  Holding regs: {hl, hr} <= {left, right} on sample_ce; a sticky fresh flag is set.
//  Frame load: on the falling edge entering slot 0, shift regs <= {hl, hr} and fresh is cleared.
//   - If fresh was 0, the previous words are resent and underrun pulses for 1 clk.
//  sample_ce coincident with a frame load:
//   - The load takes the old holding value.
//   - The new pair is latched and fresh stays set for the next frame.
//   - No underrun pulse if fresh was already set.
//  Multiple sample_ce within one frame: the last pair wins. No overflow flag.
//  sample_rate change: takes effect on the next clk's accumulation; slot and acc are not cleared; no glitch shorter than 1 clk on bclk.
//  Latency: sample_ce to MSB on i2s_data is at most 1 frame + 1 slot.
// STRUCTURE
//  - AUDIO_RATE, slot count (64) and word width (16) go in the shared audio package / include, shared with the mixer stage.
//  - One sub-module: audio_ce_gen (fractional clock-enable accumulator; params CLK_RATE; inputs rate[31:0]; output ce).
//  - The remainder (slot counter, holding and shift regs, underrun) stays in i2s_tx.
// TESTING
//  1. CLK_RATE=24576000, sample_rate=0 -> i2s_bclk period 8 clk, duty 4/4; i2s_lrclk period 512 clk, high 256.
//  2. sample_rate=1 -> bclk period 4 clk, lrclk period 256 clk; switching mid-frame gives no bclk phase shorter than 1 clk.
//  3. left=16'hA5F0, right=16'h0F0F, one sample_ce before frame -> decoded L=A5F0, R=0F0F.
//     Slot 0 and slots 17..31 of each half read 0.
//  4. No sample_ce for 2 frames -> same words repeated; underrun pulses exactly twice, 1 clk each.
//  5. sample_ce in the same clk as a frame load (left=16'h1234) -> current frame carries the old pair.
//     Next frame carries 1234; no underrun.
//  6. reset_n low mid-frame at slot 20 -> all outputs 0 in the same clk, without a clk edge.
//     After release, the first lrclk rise occurs 256 clk later at 48 kHz.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared audio constants and types for the mixer and I2S output path.
// Holds base rate, frame geometry, stereo pair type, tick-rate helper.
package i2s_tx_pkg;

   localparam int unsigned AUDIO_RATE_HZ = 48000;
   localparam int unsigned SLOTS         = 64;
   localparam int unsigned WORD_W        = 16;
   localparam int unsigned SLOT_W        = $clog2(SLOTS);
   localparam int unsigned POS_W         = SLOT_W - 1;
   localparam int unsigned IDX_W         = $clog2(WORD_W);

   typedef struct packed {
      logic [WORD_W-1:0] l;
      logic [WORD_W-1:0] r;
   } stereo_t;

   // BCLK toggle rate: two toggles per slot, doubled for 96 kHz.
   function automatic logic [31:0] bclk_rate(
      input int unsigned fs,
      input logic        dbl
   );
      logic [31:0] base;
      base      = 32'(2 * SLOTS * fs);
      bclk_rate = dbl ? (base << 1) : base;
   endfunction

endpackage

// File: rtl/audio_ce_gen.sv
// Fractional clock-enable generator: ce pulses at rate/CLK_RATE per clk.
// Ports: clk, reset_n (async low), rate[31:0] in; ce out (combinational).
module audio_ce_gen #(
   parameter int unsigned CLK_RATE = 24576000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] rate,
   output logic        ce
);

   logic [31:0] r_acc;
   logic [32:0] w_sum;
   logic        w_wrap;

   // 33-bit sum so a large rate can never wrap the compare.
   assign w_sum  = {1'b0, r_acc} + {1'b0, rate};
   assign w_wrap = (w_sum >= 33'(CLK_RATE));
   assign ce     = w_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
      end else if (w_wrap) begin
         r_acc <= 32'(w_sum - 33'(CLK_RATE));
      end else begin
         r_acc <= w_sum[31:0];
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S serialiser: 64-slot frame, 16-bit MSB-first words, 1-BCLK delay.
// In: clk, reset_n, sample_rate, sample_ce, left, right.
// Out: i2s_bclk, i2s_lrclk, i2s_data, underrun (1-clk pulse).
module i2s_tx
   import i2s_tx_pkg::*;
#(
   parameter int unsigned CLK_RATE   = 24576000,
   parameter int unsigned AUDIO_RATE = AUDIO_RATE_HZ
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_rate,
   input  logic              sample_ce,
   input  logic [WORD_W-1:0] left,
   input  logic [WORD_W-1:0] right,
   output logic              i2s_bclk,
   output logic              i2s_lrclk,
   output logic              i2s_data,
   output logic              underrun
);

   logic [31:0]       w_rate;
   logic              w_tick;
   logic              w_fall;
   logic              w_load;
   logic [SLOT_W-1:0] w_slot_nx;
   logic [POS_W-1:0]  w_pos;
   logic [IDX_W-1:0]  w_idx;
   logic [WORD_W-1:0] w_word;
   logic              w_bit;

   logic              r_bclk;
   logic [SLOT_W-1:0] r_slot;
   logic              r_lrclk;
   logic              r_data;
   stereo_t           r_hold;
   stereo_t           r_shift;
   logic              r_fresh;
   logic              r_underrun;

   assign w_rate = bclk_rate(AUDIO_RATE, sample_rate);

   audio_ce_gen #(
      .CLK_RATE (CLK_RATE)
   ) u_ce (
      .clk     (clk),
      .reset_n (reset_n),
      .rate    (w_rate),
      .ce      (w_tick)
   );

   // Slot and data for the slot being entered on this falling edge.
   always_comb begin
      w_fall    = w_tick & r_bclk;
      w_slot_nx = r_slot + SLOT_W'(1);
      w_load    = w_fall & (w_slot_nx == '0);
      w_pos     = w_slot_nx[POS_W-1:0];
      w_idx     = IDX_W'(POS_W'(WORD_W) - w_pos);
      w_word    = w_slot_nx[SLOT_W-1] ? r_shift.r : r_shift.l;
      w_bit     = 1'b0;
      if ((w_pos != '0) && (w_pos <= POS_W'(WORD_W))) begin
         w_bit = w_word[w_idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bclk  <= 1'b0;
         r_slot  <= '0;
         r_lrclk <= 1'b0;
         r_data  <= 1'b0;
      end else if (w_tick) begin
         r_bclk <= ~r_bclk;
         if (r_bclk) begin
            r_slot  <= w_slot_nx;
            r_lrclk <= w_slot_nx[SLOT_W-1];
            r_data  <= w_bit;
         end
      end
   end

   // Load reads the old holding pair; a coincident strobe keeps fresh.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold     <= '0;
         r_shift    <= '0;
         r_fresh    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_load & ~r_fresh;
         if (w_load) begin
            r_shift <= r_hold;
         end
         if (sample_ce) begin
            r_hold  <= '{l: left, r: right};
            r_fresh <= 1'b1;
         end else if (w_load) begin
            r_fresh <= 1'b0;
         end
      end
   end

   assign i2s_bclk  = r_bclk;
   assign i2s_lrclk = r_lrclk;
   assign i2s_data  = r_data;
   assign underrun  = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx against a frame-level arithmetic model.
// Covers reset, 48/96 kHz streams, underrun, coincident load, async reset.
module tb_i2s_tx;

   localparam int unsigned CLK_RATE = 24576000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        sample_rate = 1'b0;
   logic        sample_ce = 1'b0;
   logic [15:0] left = '0;
   logic [15:0] right = '0;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_data;
   logic        underrun;

   int n_cmp = 0;
   int n_bad = 0;
   int n = 0;
   int p = 4;
   int fl = 512;
   logic [15:0] m_hl, m_hr, m_sl, m_sr;
   logic        m_fresh;
   int plan[$];

   i2s_tx #(
      .CLK_RATE   (CLK_RATE),
      .AUDIO_RATE (48000)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_rate (sample_rate),
      .sample_ce   (sample_ce),
      .left        (left),
      .right       (right),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_data    (i2s_data),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (edge %0d)", tag, got, exp, n);
      end
   endtask

   function automatic logic [31:0] outs();
      return {28'd0, i2s_bclk, i2s_lrclk, i2s_data, underrun};
   endfunction

   task automatic apply_reset(input logic rate);
      reset_n   = 1'b0;
      sample_ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_state", outs(), 32'd0);
      sample_rate = rate;
      @(negedge clk);
      reset_n = 1'b1;
      p  = rate ? 2 : 4;
      fl = 128 * p;
      n  = 0;
      m_hl = '0; m_hr = '0; m_sl = '0; m_sr = '0;
      m_fresh = 1'b0;
   endtask

   // One clk: drive, advance, update model, compare all outputs.
   task automatic step(input logic ce, input logic [15:0] l,
                       input logic [15:0] r);
      int s, b;
      logic [15:0] w;
      logic [3:0] e;
      logic ld, ur;
      sample_ce = ce;
      left      = l;
      right     = r;
      @(posedge clk);
      n++;
      ld = (n % fl) == 0;
      ur = ld && !m_fresh;
      if (ld) begin
         m_sl = m_hl;
         m_sr = m_hr;
         m_fresh = 1'b0;
      end
      if (ce) begin
         m_hl = l;
         m_hr = r;
         m_fresh = 1'b1;
      end
      #1;
      s = (n / (2 * p)) % 64;
      b = s % 32;
      w = (s >= 32) ? m_sr : m_sl;
      e[3] = ((n / p) % 2) == 1;
      e[2] = (s >= 32);
      e[1] = (b >= 1 && b <= 16) ? w[16 - b] : 1'b0;
      e[0] = ur;
      chk("stream", outs(), {28'd0, e});
   endtask

   // Modes: 0 none, 1 one strobe, 2 many, 3 one + at load,
   // 4 directed A5F0/0F0F, 5 one + 1234 at load.
   task automatic run_frames(input int nf);
      int mode, off;
      logic ce;
      logic [15:0] l, r;
      for (int f = 0; f < nf; f++) begin
         mode = (plan.size() > 0) ? plan.pop_front() : $urandom_range(0, 3);
         off  = $urandom_range(1, fl - 2);
         for (int k = 1; k <= fl; k++) begin
            ce = 1'b0;
            l  = 16'($urandom);
            r  = 16'($urandom);
            case (mode)
               1: ce = (k == off);
               2: ce = ((k % 64) == (off % 64));
               3: ce = (k == off) || (k == fl);
               4: begin
                  ce = (k == 10);
                  l  = 16'hA5F0;
                  r  = 16'h0F0F;
               end
               5: begin
                  ce = (k == off) || (k == fl);
                  if (k == fl) begin
                     l = 16'h1234;
                     r = 16'h5678;
                  end
               end
               default: ce = 1'b0;
            endcase
            step(ce, l, r);
         end
      end
      sample_ce = 1'b0;
   endtask

   task automatic reset_mid();
      int guard = 0;
      while (!((n % fl) >= 164 && (n % fl) <= 167) && guard < 2 * fl) begin
         step(1'b0, 16'd0, 16'd0);
         guard++;
      end
      if (guard >= 2 * fl) chk("mid_timeout", 32'd0, 32'd1);
      chk("pre_rst_bclk", {31'd0, i2s_bclk}, 32'd1);
      #1 reset_n = 1'b0;
      #1 chk("async_rst", outs(), 32'd0);
   endtask

   task automatic rate_switch();
      int len = 0;
      bit seen = 0;
      logic prev;
      prev = i2s_bclk;
      for (int i = 0; i < 400; i++) begin
         if (i == 101) sample_rate = 1'b0;
         if (i == 257) sample_rate = 1'b1;
         @(posedge clk);
         #1;
         if (i2s_bclk === prev) begin
            len++;
         end else begin
            if (seen) begin
               chk("bclk_phase", {31'd0, (len >= 2 && len <= 4)}, 32'd1);
            end
            seen = 1;
            len  = 1;
            prev = i2s_bclk;
         end
      end
   endtask

   initial begin
      #1;
      apply_reset(1'b0);
      plan = '{4, 0, 0, 1, 5, 0, 2, 3};
      run_frames(10);
      reset_mid();
      apply_reset(1'b0);
      run_frames(2);
      apply_reset(1'b1);
      plan = '{1, 3, 0};
      run_frames(3);
      rate_switch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
